// File: rtl/pipe_portal_switch.sv
// pipe_portal_switch: routes host requests to NCHAN portals by header channel and merges portal indications round-robin
//   CLK, nRST                          clock, async active-low reset
//   req_enq__ENA/_v/__RDY              host request pipe in
//   dreq_enq__ENA/_v/__RDY             one-hot request strobe and shared message to portals
//   ind_enq__ENA/_v/__RDY              per-portal indication pipes in, message i at [i*W +: W]
//   uind_enq__ENA/_v/__RDY             merged indication pipe to host, channel field = source portal
//   err_badchan, drop_count            bad-channel drop pulse and saturating drop counter
`timescale 1ns/1ps
module pipe_portal_switch #(
  parameter int NCHAN = 4,
  parameter int HDR_W = 16,
  parameter int DATA_W = 128,
  parameter int CHAN_LSB = 12,
  parameter int DEPTH = 4,
  localparam int W = HDR_W + DATA_W
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               req_enq__ENA,
  input  logic [W-1:0]       req_enq_v,
  output logic               req_enq__RDY,
  output logic [NCHAN-1:0]   dreq_enq__ENA,
  output logic [W-1:0]       dreq_enq_v,
  input  logic [NCHAN-1:0]   dreq_enq__RDY,
  input  logic [NCHAN-1:0]   ind_enq__ENA,
  input  logic [NCHAN*W-1:0] ind_enq_v,
  output logic [NCHAN-1:0]   ind_enq__RDY,
  output logic               uind_enq__ENA,
  output logic [W-1:0]       uind_enq_v,
  input  logic               uind_enq__RDY,
  output logic               err_badchan,
  output logic [15:0]        drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = NCHAN > 1 ? $clog2(NCHAN) : 1;
  localparam int CF = DATA_W + CHAN_LSB;
  localparam logic [4:0] NCH = 5'(NCHAN);
  logic rq_valid_q, rq_valid_d;
  logic [W-1:0] rq_msg_q, rq_msg_d;
  logic [15:0] drop_q, drop_d;
  logic [3:0] rq_chan;
  logic rq_ok, rq_fire, rq_leave;
  logic [15:0] drdy, dena;
  logic [W-1:0] mem_q [NCHAN][DEPTH];
  logic [AW-1:0] wp_q [NCHAN];
  logic [AW-1:0] rp_q [NCHAN];
  logic [AW:0] cnt_q [NCHAN];
  logic [NCHAN-1:0] ne, wr, rd;
  logic out_valid_q, out_valid_d;
  logic [W-1:0] out_msg_q, out_msg_d;
  logic [CW-1:0] rr_q, rr_d, grant;
  logic found, load;
  int idx;
  assign rq_chan = rq_msg_q[CF +: 4];
  assign rq_ok = {1'b0, rq_chan} < NCH;
  assign drdy = 16'(dreq_enq__RDY);
  assign rq_fire = rq_valid_q & rq_ok & drdy[rq_chan];
  // a bad-channel request leaves unconditionally so it never blocks the stage
  assign rq_leave = rq_valid_q & (rq_ok ? drdy[rq_chan] : 1'b1);
  assign dena = {16{rq_fire}} & (16'd1 << rq_chan);
  assign dreq_enq__ENA = dena[NCHAN-1:0];
  assign dreq_enq_v = rq_msg_q;
  assign req_enq__RDY = !rq_valid_q | rq_leave;
  assign err_badchan = rq_valid_q & !rq_ok;
  assign drop_count = drop_q;
  assign uind_enq__ENA = out_valid_q & uind_enq__RDY;
  assign uind_enq_v = out_msg_q;
  assign load = (!out_valid_q | uind_enq__ENA) & found;
  always_comb begin
    rq_valid_d = req_enq__ENA | (rq_valid_q & !rq_leave);
    rq_msg_d = req_enq__ENA ? req_enq_v : rq_msg_q;
    drop_d = err_badchan && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
  end
  // FIFO ready comes from the registered count only, so a full FIFO refuses a write even while it is being read
  always_comb begin
    ind_enq__RDY = '0;
    ne = '0;
    wr = '0;
    rd = '0;
    for (int i = 0; i < NCHAN; i++) begin
      ind_enq__RDY[i] = cnt_q[i] != (AW+1)'(DEPTH);
      ne[i] = cnt_q[i] != '0;
      wr[i] = ind_enq__ENA[i] & ind_enq__RDY[i];
      rd[i] = load && grant == CW'(i);
    end
  end
  // first non-empty FIFO after the last grant
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx = 0;
    for (int k = 1; k <= NCHAN; k++) begin
      idx = (int'(rr_q) + k) % NCHAN;
      if (!found && ne[idx]) begin
        found = 1'b1;
        grant = CW'(idx);
      end
    end
  end
  always_comb begin
    out_valid_d = load | (out_valid_q & !uind_enq__ENA);
    rr_d = load ? grant : rr_q;
    out_msg_d = out_msg_q;
    if (load) begin
      out_msg_d = mem_q[grant][rp_q[grant]];
      out_msg_d[CF +: 4] = 4'(grant);
    end
  end
  always_ff @(posedge CLK)
    for (int i = 0; i < NCHAN; i++)
      if (wr[i]) mem_q[i][wp_q[i]] <= ind_enq_v[i*W +: W];
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      rq_valid_q <= 1'b0;
      rq_msg_q <= '0;
      drop_q <= '0;
      out_valid_q <= 1'b0;
      out_msg_q <= '0;
      rr_q <= CW'(NCHAN - 1);
      for (int i = 0; i < NCHAN; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rq_valid_q <= rq_valid_d;
      rq_msg_q <= rq_msg_d;
      drop_q <= drop_d;
      out_valid_q <= out_valid_d;
      out_msg_q <= out_msg_d;
      rr_q <= rr_d;
      for (int i = 0; i < NCHAN; i++) begin
        if (wr[i]) wp_q[i] <= wp_q[i] + 1'b1;
        if (rd[i]) rp_q[i] <= rp_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + (AW+1)'(wr[i]) - (AW+1)'(rd[i]);
      end
    end
endmodule
